sl_transmitter: RTL
===================

# sl_transmitter

Serial-line (SL) word transmitter: the sending end of the two-wire SL link. Takes a parallel word plus configuration from the host side and serialises it, LSB first, onto the "zeroes" and "ones" lines. The format is return-to-high pulses, an odd-parity bit, and a stop symbol. It pairs with the SL receiver and shares its configuration register layout, so the same config value programs both ends.

## Interface
- LOW_CYCLES, 14: clocks each line is driven low per symbol (1..63).
- HIGH_CYCLES, 14: clocks both lines are held high after each symbol (1..63).
- CONFIG_WIDTH, 16: config register width.
- STATUS_WIDTH, 16: status register width.

- clk  in  1  system clock, 16 MHz.
- rst  in  1  reset, synchronous, active-high.
- wr_config_w  in  CONFIG_WIDTH  new config value. PCE=bit0, BQ=bits[6:1], IRQM=bit8.
- wr_enable  in  1  config write strobe.
- tx_data_w  in  32  word to send.
- tx_start  in  1  send request, sampled each clk.
- serial_line_zeroes  out  1  zero-line, idle high.
- serial_line_ones  out  1  one-line, idle high.
- r_config_w  out  CONFIG_WIDTH  current config.
- status_w  out  STATUS_WIDTH  bit0 BUSY, bit1 DONE, bit2 REJ, others 0.
- data_status_changed  out  1  one-cycle pulse when DONE sets.

## Operation
- States: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH.
- Config writes:
  - A write is accepted only in IDLE with BQ even and 8 ≤ BQ ≤ 32.
  - Otherwise the config is unchanged and REJ is set.
  - Config reset value is 0x0010 (BQ=8).
- Starting a frame:
  - tx_start in IDLE latches the frame: shift = tx_data_w masked to the low BQ bits, with bit BQ = parity.
  - parity = ~^(masked data), so total ones over BQ+1 bits is odd.
  - A start clears DONE and REJ, sets BUSY, loads bit_cnt = BQ+1 and enters BIT_LOW.
  - PCE is stored only; parity is always transmitted.
- BIT_LOW:
  - Drive ones line low if shift[0]=1, else drive zeroes line low. The other line stays high.
  - Hold for LOW_CYCLES, then go to BIT_HIGH.
- BIT_HIGH:
  - Both lines high for HIGH_CYCLES.
  - Then shift right and decrement bit_cnt.
  - Next state is BIT_LOW if bit_cnt ≠ 0, else STOP_LOW.
- STOP_LOW: both lines low for LOW_CYCLES.
- STOP_HIGH:
  - Both lines high for HIGH_CYCLES.
  - Then return to IDLE, clear BUSY, set DONE, pulse data_status_changed.
- tx_start while BUSY: ignored, sets REJ. The frame in flight is unaffected.
- Simultaneous tx_start and wr_enable in IDLE:
  - The config write is applied first.
  - The frame uses the new BQ if the write is accepted.
- Cycle counter is 6 bits and is reloaded on every state entry.

## Timing
- Reset values:
  - serial_line_zeroes = 1, serial_line_ones = 1.
  - status_w = 0, data_status_changed = 0.
  - r_config_w = 0x0010.
- Reset applies on the first clk edge with rst high, including mid-frame. Lines are high the next cycle.
- All outputs are registered.
- tx_start sampled at edge k: the first low level appears after edge k+1.
- Frame length is (BQ+2)×(LOW_CYCLES+HIGH_CYCLES) cycles. Default BQ=8 gives 280.
- DONE and the data_status_changed pulse occur on the edge leaving STOP_HIGH.
- A new tx_start is accepted on the same edge that DONE sets, so back-to-back frames are possible.
- LOW_CYCLES and HIGH_CYCLES must each be ≥ 12 and ≤ 16 to meet the receiver strobe and end-of-bit windows.

## Configuration
- SL_TX_PARITY_INJECT_EN:
  - Defined: config bit 9 (PINV) is writable, and the transmitted parity bit is inverted when PINV=1. Used for error injection.
  - Undefined: bit 9 is forced to 0 and parity is never inverted.

## Test plan
- Reset and idle:
  - Hold rst for 2 cycles → lines 1/1, status_w=0, r_config_w=0x0010.
  - Pulse tx_start mid-frame, then assert rst → lines 1/1 on the next cycle.
- Default frame:
  - BQ=8, tx_data_w=0x000000A5 → low pulses on lines ones, zeroes, ones, zeroes, zeroes, ones, zeroes, ones, then ones (parity), then the stop symbol.
  - DONE after 280 cycles, with one data_status_changed pulse.
- Loopback to SL receiver:
  - Send 0x5A3 with BQ=16 → receiver data_w=0x000005A3, WRF=1, PEF=0, WLC=0.
  - Send 0xFFFFFFFF with BQ=32 → parity bit 1, receiver data_w=0xFFFFFFFF.
- Config rejection:
  - Write 0x0012 (BQ=9) → r_config_w stays 0x0010, REJ=1.
  - Write 0x0020 while BUSY → unchanged, REJ=1.
- Start while busy: tx_start 10 cycles into a frame → waveform identical to the undisturbed frame, REJ=1, a single DONE.
- With SL_TX_PARITY_INJECT_EN defined: config 0x0210, send 0xA5 → parity pulse on the zeroes line, receiver PEF=1.

Source files
------------

// File: rtl/sl_transmitter.sv
// SL link word transmitter: return-to-high pulses, odd parity, stop symbol.
// Optional SL_TX_PARITY_INJECT_EN makes config bit 9 invert the parity bit.
module sl_transmitter #(
    parameter int LOW_CYCLES   = 14,
    parameter int HIGH_CYCLES  = 14,
    parameter int CONFIG_WIDTH = 16,
    parameter int STATUS_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CONFIG_WIDTH-1:0] wr_config_w,
    input  logic                    wr_enable,
    input  logic [31:0]             tx_data_w,
    input  logic                    tx_start,
    output logic                    serial_line_zeroes,
    output logic                    serial_line_ones,
    output logic [CONFIG_WIDTH-1:0] r_config_w,
    output logic [STATUS_WIDTH-1:0] status_w,
    output logic                    data_status_changed
);

    typedef enum logic [2:0] {
        IDLE,
        BIT_LOW,
        BIT_HIGH,
        STOP_LOW,
        STOP_HIGH
    } state_t;

    localparam logic [5:0] LOW_LD  = 6'(LOW_CYCLES - 1);
    localparam logic [5:0] HIGH_LD = 6'(HIGH_CYCLES - 1);
    localparam logic [CONFIG_WIDTH-1:0] CFG_RST = CONFIG_WIDTH'(16'h0010);
`ifdef SL_TX_PARITY_INJECT_EN
    localparam logic [CONFIG_WIDTH-1:0] CFG_MASK = CONFIG_WIDTH'(16'h037F);
`else
    localparam logic [CONFIG_WIDTH-1:0] CFG_MASK = CONFIG_WIDTH'(16'h017F);
`endif

    state_t                  state;
    logic [5:0]              cyc;
    logic [5:0]              bit_cnt;
    logic [32:0]             shift;
    logic [CONFIG_WIDTH-1:0] cfg;
    logic                    busy;
    logic                    done;
    logic                    rej;

    logic [5:0]              wr_bq;
    logic                    wr_ok;
    logic [CONFIG_WIDTH-1:0] new_cfg;
    logic [5:0]              bq;
    logic [32:0]             data_mask;
    logic [32:0]             masked;
    logic                    par;
    logic [32:0]             frame;
    logic                    start_ok;

    // Write is resolved before the start so a same-cycle frame sees new BQ
    always_comb begin
        wr_bq   = wr_config_w[6:1];
        wr_ok   = wr_enable && (state == IDLE) && !wr_bq[0] &&
                  (wr_bq >= 6'd8) && (wr_bq <= 6'd32);
        new_cfg = wr_ok ? (wr_config_w & CFG_MASK) : cfg;
        bq        = new_cfg[6:1];
        data_mask = (33'd1 << bq) - 33'd1;
        masked    = {1'b0, tx_data_w} & data_mask;
`ifdef SL_TX_PARITY_INJECT_EN
        par = ~^masked ^ new_cfg[9];
`else
        par = ~^masked;
`endif
        frame    = masked | (33'(par) << bq);
        start_ok = tx_start &&
                   ((state == IDLE) || ((state == STOP_HIGH) && (cyc == 6'd0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            cyc                 <= 6'd0;
            bit_cnt             <= 6'd0;
            shift               <= 33'd0;
            cfg                 <= CFG_RST;
            busy                <= 1'b0;
            done                <= 1'b0;
            rej                 <= 1'b0;
            data_status_changed <= 1'b0;
            serial_line_zeroes  <= 1'b1;
            serial_line_ones    <= 1'b1;
        end else begin
            data_status_changed <= 1'b0;
            serial_line_zeroes  <= !(((state == BIT_LOW) && !shift[0]) ||
                                     (state == STOP_LOW));
            serial_line_ones    <= !(((state == BIT_LOW) && shift[0]) ||
                                     (state == STOP_LOW));
            cfg <= new_cfg;
            if (cyc != 6'd0) begin
                cyc <= cyc - 6'd1;
            end

            unique case (state)
                IDLE: begin
                end
                BIT_LOW: begin
                    if (cyc == 6'd0) begin
                        state <= BIT_HIGH;
                        cyc   <= HIGH_LD;
                    end
                end
                BIT_HIGH: begin
                    if (cyc == 6'd0) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt - 6'd1;
                        cyc     <= LOW_LD;
                        state   <= (bit_cnt != 6'd1) ? BIT_LOW : STOP_LOW;
                    end
                end
                STOP_LOW: begin
                    if (cyc == 6'd0) begin
                        state <= STOP_HIGH;
                        cyc   <= HIGH_LD;
                    end
                end
                STOP_HIGH: begin
                    if (cyc == 6'd0) begin
                        state               <= IDLE;
                        busy                <= 1'b0;
                        done                <= 1'b1;
                        data_status_changed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A start on the closing edge of a frame keeps DONE visible
            if (start_ok) begin
                shift   <= frame;
                bit_cnt <= bq + 6'd1;
                cyc     <= LOW_LD;
                state   <= BIT_LOW;
                busy    <= 1'b1;
                rej     <= 1'b0;
                if (state == IDLE) begin
                    done <= 1'b0;
                end
            end

            if ((wr_enable && !wr_ok) || (tx_start && !start_ok)) begin
                rej <= 1'b1;
            end
        end
    end

    assign r_config_w = cfg;
    assign status_w   = STATUS_WIDTH'({rej, done, busy});

endmodule
